ex_hazard_ctrl: RTL

Pipeline sequencer for the execute stage of the 16-bit core. It detects load-use and register hazards for the instruction in ID and produces registered forwarding selects for the EX operand muxes. It owns the architectural V/Z/N flag register consumed by the ALU as `flagsIn`, and generates stall/flush controls for PC, IF/ID and ID/EX on cache-miss waits and taken branches.

---
 rtl/ex_hazard_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/ex_hazard_ctrl.sv
// Execute-stage sequencer: hazard detection, registered operand forwarding selects,
// architectural {N,Z,V} flag register and PC / IF/ID / ID/EX stall and flush control.
module ex_hazard_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] id_instr,
    input  logic        id_valid,
    input  logic [3:0]  ex_rd,
    input  logic [3:0]  mem_rd,
    input  logic        ex_regwrite,
    input  logic        mem_regwrite,
    input  logic        ex_memread,
    input  logic [2:0]  ex_flags,
    input  logic        ex_flag_upd,
    input  logic        branch_taken,
    input  logic        mem_busy,
    output logic        stall_pc,
    output logic        stall_ifid,
    output logic        stall_all,
    output logic        flush_ifid,
    output logic        flush_idex,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic [2:0]  flags_q,
    output logic [15:0] stall_cnt
);

    // Opcode values mirror the SW / B / JAL macros of defines.v.
    localparam logic [3:0] OP_SW  = 4'h9;
    localparam logic [3:0] OP_B   = 4'hC;
    localparam logic [3:0] OP_JAL = 4'hD;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic [1:0] {
        RUN,
        LU_STALL,
        MEM_WAIT
    } state_t;

    state_t     state;
    logic [3:0] opcode;
    logic [3:0] rs;
    logic [3:0] rt;
    logic       rs_used;
    logic       rt_used;
    logic       ex_hit_a;
    logic       ex_hit_b;
    logic       mem_hit_a;
    logic       mem_hit_b;
    logic       load_use;
    logic [1:0] fwd_a_d;
    logic [1:0] fwd_b_d;

    // Source-field decode for the instruction sitting in ID.
    assign opcode  = id_instr[15:12];
    assign rs      = id_instr[7:4];
    assign rt      = (opcode == OP_SW) ? id_instr[11:8] : id_instr[3:0];
    assign rs_used = (opcode != OP_B) && (opcode != OP_JAL);
    assign rt_used = !id_instr[15] || (opcode == OP_SW);

    // r0 is hard-wired zero, so it never matches a producer.
    assign ex_hit_a  = rs_used && (rs != 4'd0) && ex_regwrite  && (ex_rd  == rs);
    assign ex_hit_b  = rt_used && (rt != 4'd0) && ex_regwrite  && (ex_rd  == rt);
    assign mem_hit_a = rs_used && (rs != 4'd0) && mem_regwrite && (mem_rd == rs);
    assign mem_hit_b = rt_used && (rt != 4'd0) && mem_regwrite && (mem_rd == rt);

    assign fwd_a_d = ex_hit_a ? FWD_EX : (mem_hit_a ? FWD_MEM : FWD_RF);
    assign fwd_b_d = ex_hit_b ? FWD_EX : (mem_hit_b ? FWD_MEM : FWD_RF);

    assign load_use = id_valid && ex_memread && (ex_hit_a || ex_hit_b);

    // Priority: cache miss freezes everything, then a taken branch squashes ID/EX,
    // then a load-use hazard inserts its single bubble.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        stall_pc   = 1'b0;
        stall_ifid = 1'b0;
        stall_all  = 1'b0;
        flush_ifid = 1'b0;
        flush_idex = 1'b0;
        if (rst_n) begin
            if (mem_busy) begin
                stall_pc   = 1'b1;
                stall_ifid = 1'b1;
                stall_all  = 1'b1;
            end else if (branch_taken) begin
                flush_ifid = 1'b1;
                flush_idex = 1'b1;
            end else if (load_use && (state != LU_STALL)) begin
                stall_pc   = 1'b1;
                stall_ifid = 1'b1;
                flush_idex = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
            state <= RUN;
        end else begin
            case (state)
                RUN: begin
                    if (mem_busy)
                        state <= MEM_WAIT;
                    else if (!branch_taken && load_use)
                        state <= LU_STALL;
                end
                LU_STALL: state <= RUN;
                MEM_WAIT: begin
                    if (!mem_busy)
                        state <= RUN;
                end
                default:  state <= RUN;
            endcase
        end
    end

    // Selects are captured as the instruction leaves ID and applied while it is in EX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_a <= FWD_RF;
            fwd_b <= FWD_RF;
        end else if (flush_idex) begin
            fwd_a <= FWD_RF;
            fwd_b <= FWD_RF;
        end else if (!stall_all && !stall_ifid) begin
            fwd_a <= fwd_a_d;
            fwd_b <= fwd_b_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            flags_q <= 3'b000;
        else if (ex_flag_upd && !stall_all)
            flags_q <= ex_flags;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= 16'd0;
        else if (stall_pc && (stall_cnt != 16'hFFFF))
            stall_cnt <= stall_cnt + 16'd1;
    end

endmodule
